// File: rtl/unary_mac_sequencer.sv
// unary_mac_sequencer: feeds operand pairs from a small FIFO to a unary_binary_MAC,
// one outstanding operation at a time, and accumulates the MAC results into a
// per-vector dot product that is presented on a valid/ready result port.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b/in_last   operand stream (in_last tags final element)
//   mac_valid/mac_a/mac_b             issue pulse and held operands to the MAC
//   mac_ready/mac_out                 MAC completion pulse and result
//   res_valid/res_ready/res_data/res_count  dot-product result handshake
module unary_mac_sequencer #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned SETS  = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SETS*SIZE-1:0]   in_a,
    input  logic [SETS*SIZE-1:0]   in_b,
    input  logic                   in_last,
    output logic                   mac_valid,
    output logic [SETS*SIZE-1:0]   mac_a,
    output logic [SETS*SIZE-1:0]   mac_b,
    input  logic                   mac_ready,
    input  logic [2*SIZE+SETS-1:0] mac_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic [CNT_W-1:0]       res_count
);

    localparam int unsigned OP_W = SETS * SIZE;
    localparam int unsigned E_W  = 2 * OP_W + 1;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t            state;
    logic [E_W-1:0]    mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [E_W-1:0]    head;
    logic              push;
    logic              pop;
    logic              last_q;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    // FIFO entry layout: {a, b, last}
    assign push = in_valid && in_ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign head = mem[rd_ptr];

    always_comb begin
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // Storage needs no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_last};
        end
    end

    // Pointers, occupancy and the registered not-full flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nxt;
            in_ready <= (count_nxt != CW'(DEPTH));
        end
    end

    // Issue/collect state machine; mac_valid is raised on entry to ISSUE only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mac_valid <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            last_q    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
        end else begin
            mac_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        mac_a     <= head[E_W-1 -: OP_W];
                        mac_b     <= head[OP_W -: OP_W];
                        last_q    <= head[0];
                        mac_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mac_ready) begin
                        acc       <= acc + ACC_W'(mac_out);
                        cnt       <= cnt + CNT_W'(1);
                        res_valid <= last_q;
                        state     <= last_q ? RESULT : IDLE;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sum and count are held in registers and only change outside RESULT
    assign res_data  = acc;
    assign res_count = cnt;

endmodule

// File: tb/tb_unary_mac_sequencer.sv
// tb_unary_mac_sequencer: scoreboard bench for unary_mac_sequencer with a
// behavioural MAC (product of a and b, optional forced 511 result, optional hold).
module tb_unary_mac_sequencer;

    localparam int unsigned SIZE  = 4;
    localparam int unsigned SETS  = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned OP_W  = SETS * SIZE;
    localparam int unsigned MO_W  = 2 * SIZE + SETS;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] cnt;
    } res_t;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              in_last;
    logic              mac_valid;
    logic [OP_W-1:0]   mac_a;
    logic [OP_W-1:0]   mac_b;
    logic              mac_rdy_m;
    logic              spur;
    logic [MO_W-1:0]   mac_out;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;

    bit                mac_hold;
    bit                force511;
    int                mac_lat;

    int                n_vec;
    int                n_miss;

    logic [2*OP_W-1:0] iss_q [$];
    res_t              res_q [$];

    unary_mac_sequencer #(
        .SIZE(SIZE), .SETS(SETS), .DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_last(in_last),
        .mac_valid(mac_valid),
        .mac_a(mac_a),
        .mac_b(mac_b),
        .mac_ready(mac_rdy_m | spur),
        .mac_out(mac_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_count(res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [ACC_W-1:0] data, input logic [CNT_W-1:0] c);
        res_t r;
        r.data = data;
        r.cnt  = c;
        res_q.push_back(r);
    endtask

    // Offer one pair and hold it until accepted (bounded)
    task automatic push(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic last);
        bit took;
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        do begin
            took = in_ready;
            step();
            guard++;
        end while (!took && guard < 2000);
        in_valid = 1'b0;
        if (took) iss_q.push_back({a, b});
        else begin
            n_vec++;
            n_miss++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 2000 cycles");
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((res_q.size() != 0 || iss_q.size() != 0) && guard < 5000) begin
            step();
            guard++;
        end
        n_vec++;
        if (guard >= 5000) begin
            n_miss++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", res_q.size());
        end
        repeat (3) step();
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  in_ready,  1);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_mac_a",     mac_a,     0);
        check("rst_mac_b",     mac_b,     0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data",  res_data,  0);
        check("rst_res_count", res_count, 0);
    endtask

    // Behavioural MAC: checks issue order, single outstanding op and operand stability
    initial begin
        logic [2*OP_W-1:0] e;
        logic [OP_W-1:0]   ca;
        logic [OP_W-1:0]   cb;
        int                k;
        mac_rdy_m = 1'b0;
        mac_out   = '0;
        forever begin
            @(negedge clk);
            if (mac_valid && reset_n) begin
                if (iss_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_issue: got a=%0d b=%0d expected no issue", mac_a, mac_b);
                end else begin
                    e = iss_q.pop_front();
                    check("issue_a", mac_a, e[2*OP_W-1 -: OP_W]);
                    check("issue_b", mac_b, e[OP_W-1:0]);
                end
                ca = mac_a;
                cb = mac_b;
                step();
                k = 0;
                while (reset_n && (mac_hold || k < mac_lat)) begin
                    check("wait_no_reissue", mac_valid, 0);
                    check("wait_a_stable",   mac_a,     ca);
                    step();
                    k++;
                end
                if (reset_n) begin
                    check("ready_b_stable", mac_b, cb);
                    mac_out   = force511 ? MO_W'(511) : MO_W'(ca) * MO_W'(cb);
                    mac_rdy_m = 1'b1;
                    step();
                    mac_rdy_m = 1'b0;
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on every accepted result
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (reset_n && res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_result: got %0d expected none", res_data);
                end else begin
                    e = res_q.pop_front();
                    check("res_data",  res_data,  e.data);
                    check("res_count", res_count, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        n_vec     = 0;
        n_miss    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        spur      = 1'b0;
        res_ready = 1'b1;
        mac_hold  = 1'b0;
        force511  = 1'b0;
        mac_lat   = 1;
        step();
        step();
        check_reset_outputs();
        reset_n = 1'b1;
        step();

        // Single element: 3*5
        expect_result(15, 1);
        push(3, 5, 1);
        drain();

        // Four elements: 2 + 225 + 0 + 28
        expect_result(255, 4);
        push(1, 2, 0);
        push(15, 15, 0);
        push(0, 9, 0);
        push(7, 4, 1);
        drain();

        // FIFO full while the first pair is held in WAIT: 1+6+20+42+72+110
        mac_hold = 1'b1;
        expect_result(251, 6);
        push(1, 1, 0);
        push(2, 3, 0);
        push(4, 5, 0);
        push(6, 7, 0);
        push(8, 9, 0);
        check("full_in_ready", in_ready, 0);
        repeat (5) begin
            step();
            check("full_in_ready_held", in_ready, 0);
        end
        mac_hold = 1'b0;
        push(10, 11, 1);
        drain();

        // Result backpressure: 1*2 held while next vector fills the FIFO
        res_ready = 1'b0;
        expect_result(2, 1);
        push(1, 2, 1);
        guard = 0;
        while (!res_valid && guard < 100) begin
            step();
            guard++;
        end
        check("bp_res_valid", res_valid, 1);
        expect_result(30, 4);
        push(1, 1, 0);
        push(2, 2, 0);
        push(3, 3, 0);
        push(4, 4, 1);
        check("bp_in_ready_full", in_ready, 0);
        repeat (16) begin
            check("bp_valid_stable", res_valid, 1);
            check("bp_data_stable",  res_data,  2);
            check("bp_no_issue",     mac_valid, 0);
            step();
        end
        res_ready = 1'b1;
        drain();

        // Spurious mac_ready in IDLE mid-vector must not touch the sum: 9 + 1
        expect_result(10, 2);
        push(3, 3, 0);
        repeat (10) step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        push(1, 1, 1);
        drain();

        // Count wrap: 300 single-pair vectors, then 257 elements of 511
        force511 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            expect_result(511, 1);
            push(OP_W'(i % 16), OP_W'((i / 16) % 16), 1);
        end
        expect_result(131327, 1);
        for (int i = 0; i < 257; i++) begin
            push(OP_W'(i % 16), OP_W'((i + 5) % 16), (i == 256) ? 1'b1 : 1'b0);
        end
        drain();
        force511 = 1'b0;

        // Reset while in WAIT with three pairs queued
        mac_hold = 1'b1;
        push(1, 1, 0);
        push(2, 2, 0);
        push(3, 3, 0);
        push(4, 4, 0);
        step();
        step();
        reset_n = 1'b0;
        step();
        iss_q.delete();
        check_reset_outputs();
        mac_hold = 1'b0;
        reset_n  = 1'b1;
        step();
        expect_result(6, 1);
        push(2, 3, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
